// File: rtl/stopwatch_lap_ctrl_pkg.sv
// Shared definitions for the stopwatch control slice.
//   state_e    : controller state encoding (IDLE=00, RUN=01, PAUSE=10)
//   TIME_W     : width of one BCD time sample (three digits)
//   LAP_DEPTH  : lap buffer entries (power of two)
//   PTR_W      : lap pointer width
//   DB_CNT_SIM : short debounce length used in simulation
package stopwatch_lap_ctrl_pkg;

  localparam int unsigned TIME_W     = 12;
  localparam int unsigned LAP_DEPTH  = 4;
  localparam int unsigned PTR_W      = $clog2(LAP_DEPTH);
  localparam int unsigned DB_CNT_SIM = 4;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StRun   = 2'b01,
    StPause = 2'b10
  } state_e;

endpackage

// File: rtl/stopwatch_lap_ctrl_if.sv
// Button, time and status bundle between the board side and the controller.
//   i_fStart/i_fStop/i_fRecord : raw active-low buttons
//   i_Time                     : live BCD time from the counter
//   o_Run/o_Clr                : counter enable / clear
//   o_State                    : controller state
//   o_Lap/o_LapIdx/o_LapCnt    : displayed lap, its slot, valid lap count
// master = board/counter side, slave = controller.
interface stopwatch_lap_ctrl_if;
  import stopwatch_lap_ctrl_pkg::*;

  logic              i_fStart;
  logic              i_fStop;
  logic              i_fRecord;
  logic [TIME_W-1:0] i_Time;
  logic              o_Run;
  logic              o_Clr;
  logic [1:0]        o_State;
  logic [TIME_W-1:0] o_Lap;
  logic [PTR_W-1:0]  o_LapIdx;
  logic [2:0]        o_LapCnt;

  modport master (
    output i_fStart, i_fStop, i_fRecord, i_Time,
    input  o_Run, o_Clr, o_State, o_Lap, o_LapIdx, o_LapCnt
  );

  modport slave (
    input  i_fStart, i_fStop, i_fRecord, i_Time,
    output o_Run, o_Clr, o_State, o_Lap, o_LapIdx, o_LapCnt
  );

endinterface

// File: rtl/stopwatch_lap_ctrl_btn_debounce.sv
// Button front end: 2-flop synchronizer, debounce counter and press pulse.
//   clk, rst_n : clock, asynchronous active-low reset
//   raw        : raw active-low button, asynchronous to clk
//   press      : one-cycle pulse when the accepted level falls 1->0
module stopwatch_lap_ctrl_btn_debounce #(
  parameter int unsigned DB_CNT = 2_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic press
);

  localparam int unsigned CntW = (DB_CNT > 1) ? $clog2(DB_CNT) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DB_CNT - 1);

  logic            sync1_q, sync2_q;
  logic            level_q, level_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            press_q, press_d;

  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    press_d = 1'b0;
    // Count only while the synced level disagrees with the accepted one.
    if (sync2_q != level_q) begin
      if (cnt_q == CntMax) begin
        level_d = sync2_q;
        press_d = ~sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/stopwatch_lap_ctrl.sv
// Stopwatch control unit: button debouncing, IDLE/RUN/PAUSE sequencing and a
// circular lap buffer with a scroll pointer for review in PAUSE.
//   i_Clk : system clock
//   i_Rst : asynchronous active-low reset
//   bus   : buttons and live time in; run/clear, state and lap display out
// All outputs are registered.
module stopwatch_lap_ctrl
  import stopwatch_lap_ctrl_pkg::*;
#(
  parameter int unsigned DB_CNT = 2_000_000
) (
  input  logic                 i_Clk,
  input  logic                 i_Rst,
  stopwatch_lap_ctrl_if.slave  bus
);

  localparam logic [2:0] CntFull = 3'(LAP_DEPTH);

  logic start_ev, stop_ev, rec_ev;

  stopwatch_lap_ctrl_btn_debounce #(.DB_CNT(DB_CNT)) u_db_start (
    .clk   (i_Clk),
    .rst_n (i_Rst),
    .raw   (bus.i_fStart),
    .press (start_ev)
  );

  stopwatch_lap_ctrl_btn_debounce #(.DB_CNT(DB_CNT)) u_db_stop (
    .clk   (i_Clk),
    .rst_n (i_Rst),
    .raw   (bus.i_fStop),
    .press (stop_ev)
  );

  stopwatch_lap_ctrl_btn_debounce #(.DB_CNT(DB_CNT)) u_db_record (
    .clk   (i_Clk),
    .rst_n (i_Rst),
    .raw   (bus.i_fRecord),
    .press (rec_ev)
  );

  state_e            state_q, state_d;
  logic [PTR_W-1:0]  wp_q, wp_d;
  logic [PTR_W-1:0]  idx_q, idx_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [2:0]        cnt_m1;
  logic [TIME_W-1:0] lap_q [LAP_DEPTH];
  logic [TIME_W-1:0] lap_d [LAP_DEPTH];
  logic [TIME_W-1:0] lap_out_q, lap_out_d;
  logic              run_q, run_d;
  logic              clr_q, clr_d;

  always_comb begin
    state_d = state_q;
    wp_d    = wp_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    lap_d   = lap_q;
    cnt_m1  = cnt_q - 3'd1;

    // Priority Stop > Start > Record; lower events in the same cycle are dropped.
    case (state_q)
      StIdle: begin
        wp_d  = '0;
        idx_d = '0;
        cnt_d = '0;
        if (!stop_ev && start_ev) begin
          state_d = StRun;
          idx_d   = '1; // newest slot is wp-1 with wp = 0
        end
      end
      StRun: begin
        if (stop_ev || start_ev) begin
          state_d = StPause; // idx already tracks wp-1, which is the entry view
        end else if (rec_ev) begin
          lap_d[wp_q] = bus.i_Time;
          wp_d        = wp_q + 1'b1;
          idx_d       = wp_q;
          cnt_d       = (cnt_q == CntFull) ? cnt_q : cnt_q + 3'd1;
        end
      end
      StPause: begin
        if (stop_ev) begin
          state_d = StIdle;
          wp_d    = '0;
          idx_d   = '0;
          cnt_d   = '0;
        end else if (start_ev) begin
          state_d = StRun;
          idx_d   = wp_q - 1'b1;
        end else if (rec_ev && cnt_q != 3'd0) begin
          // A partly filled buffer wraps within its valid slots only.
          if (cnt_q == CntFull || idx_q != '0) begin
            idx_d = idx_q - 1'b1;
          end else begin
            idx_d = cnt_m1[PTR_W-1:0];
          end
        end
      end
      default: begin
        state_d = StIdle;
        wp_d    = '0;
        idx_d   = '0;
        cnt_d   = '0;
      end
    endcase

    lap_out_d = (cnt_d == 3'd0) ? '0 : lap_d[idx_d];
    run_d     = (state_d == StRun);
    clr_d     = (state_d == StIdle);
  end

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      state_q   <= StIdle;
      wp_q      <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      lap_out_q <= '0;
      run_q     <= 1'b0;
      clr_q     <= 1'b1;
      for (int i = 0; i < LAP_DEPTH; i++) begin
        lap_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      wp_q      <= wp_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      lap_out_q <= lap_out_d;
      run_q     <= run_d;
      clr_q     <= clr_d;
      for (int i = 0; i < LAP_DEPTH; i++) begin
        lap_q[i] <= lap_d[i];
      end
    end
  end

  assign bus.o_State  = state_q;
  assign bus.o_Run    = run_q;
  assign bus.o_Clr    = clr_q;
  assign bus.o_Lap    = lap_out_q;
  assign bus.o_LapIdx = idx_q;
  assign bus.o_LapCnt = cnt_q;

endmodule

// File: tb/tb_stopwatch_lap_ctrl.sv
module tb_stopwatch_lap_ctrl;
  import stopwatch_lap_ctrl_pkg::*;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  stopwatch_lap_ctrl_if bus ();

  stopwatch_lap_ctrl #(.DB_CNT(DB_CNT_SIM)) dut (
    .i_Clk (clk),
    .i_Rst (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Hold the selected buttons low, then release and let the release settle.
  task automatic press(input bit s, input bit p, input bit r);
    bus.i_fStart  = ~s;
    bus.i_fStop   = ~p;
    bus.i_fRecord = ~r;
    tick(10);
    bus.i_fStart  = 1'b1;
    bus.i_fStop   = 1'b1;
    bus.i_fRecord = 1'b1;
    tick(8);
  endtask

  task automatic record(input logic [TIME_W-1:0] t);
    bus.i_Time = t;
    press(1'b0, 1'b0, 1'b1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"}, 32'(bus.o_State), 32'h0);
    chk({tag, "_run"}, 32'(bus.o_Run), 32'h0);
    chk({tag, "_clr"}, 32'(bus.o_Clr), 32'h1);
    chk({tag, "_lap"}, 32'(bus.o_Lap), 32'h0);
    chk({tag, "_idx"}, 32'(bus.o_LapIdx), 32'h0);
    chk({tag, "_cnt"}, 32'(bus.o_LapCnt), 32'h0);
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.i_fStart  = 1'b1;
    bus.i_fStop   = 1'b1;
    bus.i_fRecord = 1'b1;
    bus.i_Time    = '0;
    tick(3);
    chk_reset_vals("rst");
    rst_n = 1'b1;
    tick(2);
    chk_reset_vals("post_rst");

    // 3-cycle glitch is filtered
    bus.i_fStart = 1'b0;
    tick(3);
    bus.i_fStart = 1'b1;
    tick(10);
    chk("glitch_state", 32'(bus.o_State), 32'h0);

    // Held press: state changes exactly on the 7th edge
    bus.i_fStart = 1'b0;
    tick(6);
    chk("lat6_state", 32'(bus.o_State), 32'h0);
    tick(1);
    chk("lat7_state", 32'(bus.o_State), 32'h1);
    chk("lat7_run", 32'(bus.o_Run), 32'h1);
    chk("lat7_clr", 32'(bus.o_Clr), 32'h0);
    tick(3);
    bus.i_fStart = 1'b1;
    tick(8);
    chk("hold_once_state", 32'(bus.o_State), 32'h1);

    // Two laps in RUN
    record(12'h012);
    record(12'h034);
    chk("run2_cnt", 32'(bus.o_LapCnt), 32'h2);
    chk("run2_lap", 32'(bus.o_Lap), 32'h034);
    chk("run2_idx", 32'(bus.o_LapIdx), 32'h1);

    // PAUSE scroll with a partly filled buffer
    press(1'b1, 1'b0, 1'b0);
    chk("p2_state", 32'(bus.o_State), 32'h2);
    chk("p2_run", 32'(bus.o_Run), 32'h0);
    chk("p2_clr", 32'(bus.o_Clr), 32'h0);
    chk("p2_entry_lap", 32'(bus.o_Lap), 32'h034);
    record(12'h999);
    chk("p2_scroll1_lap", 32'(bus.o_Lap), 32'h012);
    chk("p2_scroll1_idx", 32'(bus.o_LapIdx), 32'h0);
    record(12'h999);
    chk("p2_scroll2_lap", 32'(bus.o_Lap), 32'h034);
    chk("p2_scroll2_idx", 32'(bus.o_LapIdx), 32'h1);
    press(1'b1, 1'b0, 1'b0);
    chk("p2_resume_state", 32'(bus.o_State), 32'h1);
    chk("p2_resume_lap", 32'(bus.o_Lap), 32'h034);
    chk("p2_resume_cnt", 32'(bus.o_LapCnt), 32'h2);

    // Stop in RUN pauses, then Stop+Start together in PAUSE goes to IDLE
    press(1'b0, 1'b1, 1'b0);
    chk("stop_run_state", 32'(bus.o_State), 32'h2);
    press(1'b1, 1'b1, 1'b0);
    chk_reset_vals("both");

    // Wraparound: five laps 1..5 overwrite slot 0
    press(1'b1, 1'b0, 1'b0);
    chk("run_again_state", 32'(bus.o_State), 32'h1);
    for (int k = 1; k <= 5; k++) begin
      record(TIME_W'(k));
    end
    chk("wrap_cnt", 32'(bus.o_LapCnt), 32'h4);
    chk("wrap_lap", 32'(bus.o_Lap), 32'h5);
    chk("wrap_idx", 32'(bus.o_LapIdx), 32'h0);
    press(1'b1, 1'b0, 1'b0);
    chk("wrap_pause_lap", 32'(bus.o_Lap), 32'h5);
    record(12'h0);
    chk("wrap_scroll1", 32'(bus.o_Lap), 32'h4);
    record(12'h0);
    chk("wrap_scroll2", 32'(bus.o_Lap), 32'h3);
    record(12'h0);
    chk("wrap_scroll3", 32'(bus.o_Lap), 32'h2);
    record(12'h0);
    chk("wrap_scroll4", 32'(bus.o_Lap), 32'h5);
    chk("wrap_scroll4_idx", 32'(bus.o_LapIdx), 32'h0);

    // Stop in PAUSE clears; then three laps and an asynchronous reset mid-press
    press(1'b0, 1'b1, 1'b0);
    chk_reset_vals("stop_pause");
    press(1'b0, 1'b1, 1'b0);
    chk("idle_stop_ignored", 32'(bus.o_State), 32'h0);
    record(12'h111);
    chk("idle_rec_ignored", 32'(bus.o_LapCnt), 32'h0);
    press(1'b1, 1'b0, 1'b0);
    record(12'h007);
    record(12'h008);
    record(12'h009);
    chk("r3_cnt", 32'(bus.o_LapCnt), 32'h3);
    chk("r3_lap", 32'(bus.o_Lap), 32'h009);
    bus.i_fStart = 1'b0;
    tick(3);
    #1;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("async");
    bus.i_fStart = 1'b1;
    tick(3);
    rst_n = 1'b1;
    tick(12);
    chk("after_rst_state", 32'(bus.o_State), 32'h0);
    press(1'b1, 1'b0, 1'b0);
    chk("after_rst_run", 32'(bus.o_State), 32'h1);
    chk("after_rst_cnt", 32'(bus.o_LapCnt), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
